// File: rtl/monitorizacion_bateria.sv
// Dual-battery charge monitor: per-battery low-charge warnings plus a
// debounced one-hot health class derived from the combined charge.
module monitorizacion_bateria #(
  parameter int unsigned WARN_LEVEL    = 4,
  parameter int unsigned TH_REGULAR    = 8,
  parameter int unsigned TH_ACEPTABLE  = 16,
  parameter int unsigned TH_OPTIMO     = 24,
  parameter int unsigned STABLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] carga_bateria1,
  input  logic [3:0] carga_bateria2,
  output logic       advertencia_bateria_1,
  output logic       advertencia_bateria_2,
  output logic       optimo,
  output logic       aceptable,
  output logic       regular,
  output logic       critico
);

  localparam int unsigned CARGA_W = 4;
  localparam int unsigned SUMA_W  = 5;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CLASE_W = 4;

  // One-hot class encoding: {optimo, aceptable, regular, critico}
  localparam logic [CLASE_W-1:0] CLASE_OPTIMO    = 4'b1000;
  localparam logic [CLASE_W-1:0] CLASE_ACEPTABLE = 4'b0100;
  localparam logic [CLASE_W-1:0] CLASE_REGULAR   = 4'b0010;
  localparam logic [CLASE_W-1:0] CLASE_CRITICO   = 4'b0001;

  logic [SUMA_W-1:0]  w_suma;
  logic [CLASE_W-1:0] w_candidato;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_confirmar;

  logic               r_adv1;
  logic               r_adv2;
  logic [CLASE_W-1:0] r_pendiente;
  logic [CNT_W-1:0]   r_cnt;
  logic [CLASE_W-1:0] r_clase;

  // Combined charge, widened so 15+15 cannot overflow
  assign w_suma = SUMA_W'(carga_bateria1) + SUMA_W'(carga_bateria2);

  // Candidate class from the combined charge thresholds
  always_comb begin
    w_candidato = CLASE_CRITICO;
    if (w_suma >= SUMA_W'(TH_OPTIMO)) begin
      w_candidato = CLASE_OPTIMO;
    end else if (w_suma >= SUMA_W'(TH_ACEPTABLE)) begin
      w_candidato = CLASE_ACEPTABLE;
    end else if (w_suma >= SUMA_W'(TH_REGULAR)) begin
      w_candidato = CLASE_REGULAR;
    end
  end

  // Run length of the candidate after this edge; commit once it reaches the target
  always_comb begin
    w_cnt_nxt = CNT_W'(1);
    if (w_candidato == r_pendiente) begin
      if (r_cnt >= CNT_W'(STABLE_CYCLES)) begin
        w_cnt_nxt = r_cnt;
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
    w_confirmar = (w_cnt_nxt >= CNT_W'(STABLE_CYCLES));
  end

  // Low-charge warnings, one cycle latency, no filtering
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_adv1 <= 1'b1;
      r_adv2 <= 1'b1;
    end else begin
      r_adv1 <= (carga_bateria1 < CARGA_W'(WARN_LEVEL));
      r_adv2 <= (carga_bateria2 < CARGA_W'(WARN_LEVEL));
    end
  end

  // Stability filter: track pending class and its run length, commit when stable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pendiente <= CLASE_CRITICO;
      r_cnt       <= '0;
      r_clase     <= CLASE_CRITICO;
    end else begin
      r_pendiente <= w_candidato;
      r_cnt       <= w_cnt_nxt;
      if (w_confirmar) begin
        r_clase <= w_candidato;
      end
    end
  end

  assign advertencia_bateria_1 = r_adv1;
  assign advertencia_bateria_2 = r_adv2;
  assign optimo    = r_clase[3];
  assign aceptable = r_clase[2];
  assign regular   = r_clase[1];
  assign critico   = r_clase[0];

endmodule

// File: tb/tb_monitorizacion_bateria.sv
// Directed self-checking bench for monitorizacion_bateria.
module tb_monitorizacion_bateria;

  logic       clk;
  logic       rst;
  logic [3:0] carga_bateria1;
  logic [3:0] carga_bateria2;
  logic       advertencia_bateria_1;
  logic       advertencia_bateria_2;
  logic       optimo;
  logic       aceptable;
  logic       regular;
  logic       critico;

  localparam logic [3:0] OPT = 4'b1000;
  localparam logic [3:0] ACE = 4'b0100;
  localparam logic [3:0] REG = 4'b0010;
  localparam logic [3:0] CRI = 4'b0001;

  int n_pass;
  int n_total;

  monitorizacion_bateria dut (
    .clk                   (clk),
    .rst                   (rst),
    .carga_bateria1        (carga_bateria1),
    .carga_bateria2        (carga_bateria2),
    .advertencia_bateria_1 (advertencia_bateria_1),
    .advertencia_bateria_2 (advertencia_bateria_2),
    .optimo                (optimo),
    .aceptable             (aceptable),
    .regular               (regular),
    .critico               (critico)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic aplicar(input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    carga_bateria1 = a;
    carga_bateria2 = b;
  endtask

  task automatic chk_clase(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {optimo, aceptable, regular, critico};
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s class observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic chk_adv(input string tag, input logic [1:0] exp);
    logic [1:0] obs;
    obs = {advertencia_bateria_1, advertencia_bateria_2};
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s warnings observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic mantener(input logic [3:0] a, input logic [3:0] b, input int n,
                          input string tag, input logic [3:0] clase, input logic [1:0] adv);
    aplicar(a, b);
    repeat (n) tick();
    chk_clase(tag, clase);
    chk_adv(tag, adv);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    carga_bateria1 = 4'd15;
    carga_bateria2 = 4'd15;

    // Reset held with full batteries
    repeat (3) tick();
    chk_clase("rst_hold", CRI);
    chk_adv("rst_hold", 2'b11);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk_adv("rel_edge1", 2'b00);
    chk_clase("rel_edge1", CRI);
    tick();
    chk_clase("rel_edge2", OPT);

    // Main sequence, each held 10 cycles
    mantener(4'd0,  4'd0,  10, "seq_0_0",   CRI, 2'b11);
    mantener(4'd8,  4'd0,  10, "seq_8_0",   REG, 2'b01);
    mantener(4'd8,  4'd8,  10, "seq_8_8",   ACE, 2'b00);
    mantener(4'd15, 4'd0,  10, "seq_15_0",  REG, 2'b01);
    mantener(4'd15, 4'd15, 10, "seq_15_15", OPT, 2'b00);
    mantener(4'd5,  4'd6,  10, "seq_5_6",   REG, 2'b00);

    // Threshold and warning boundaries
    mantener(4'd7,  4'd0, 4, "sum7",   CRI, 2'b01);
    mantener(4'd8,  4'd0, 4, "sum8",   REG, 2'b01);
    mantener(4'd15, 4'd1, 4, "sum16",  ACE, 2'b01);
    mantener(4'd15, 4'd8, 4, "sum23",  ACE, 2'b00);
    mantener(4'd15, 4'd9, 4, "sum24",  OPT, 2'b00);
    mantener(4'd3,  4'd4, 4, "adv3_4", CRI, 2'b10);
    mantener(4'd4,  4'd3, 4, "adv4_3", CRI, 2'b01);
    mantener(4'd0,  4'd15, 4, "sum15", REG, 2'b10);

    // One-sample glitch must not disturb committed optimo
    mantener(4'd15, 4'd15, 4, "glitch_pre", OPT, 2'b00);
    aplicar(4'd0, 4'd0);
    tick();
    chk_adv("glitch_adv", 2'b11);
    chk_clase("glitch_e0", OPT);
    aplicar(4'd15, 4'd15);
    tick();
    chk_adv("glitch_back", 2'b00);
    chk_clase("glitch_e1", OPT);
    tick();
    chk_clase("glitch_e2", OPT);

    // Step latency: warnings at edge k, class at edge k+1
    mantener(4'd0, 4'd0, 4, "lat_pre", CRI, 2'b11);
    aplicar(4'd8, 4'd8);
    tick();
    chk_adv("lat_k", 2'b00);
    chk_clase("lat_k", CRI);
    tick();
    chk_clase("lat_k1", ACE);

    // Asynchronous reset between edges
    mantener(4'd15, 4'd15, 4, "arst_pre", OPT, 2'b00);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_clase("arst_imm", CRI);
    chk_adv("arst_imm", 2'b11);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk_clase("arst_rel1", CRI);
    chk_adv("arst_rel1", 2'b00);
    tick();
    chk_clase("arst_rel2", OPT);

    // Reset mid-filter discards the pending class
    mantener(4'd0, 4'd0, 4, "mid_pre", CRI, 2'b11);
    aplicar(4'd8, 4'd8);
    tick();
    #1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk_clase("mid_rel1", CRI);
    tick();
    chk_clase("mid_rel2", ACE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/monitorizacion_bateria.md
Name: monitorizacion_bateria

Overview:
- Dual-battery charge monitor for the power-management subsystem.
- Samples two 4-bit charge levels every clock and raises a per-battery low-charge warning.
- Classifies the combined charge into four one-hot health levels: optimo, aceptable, regular, critico.
- The health class is filtered so a new class commits only after it has been stable for a set number of cycles; outputs feed status LEDs and the supervisor.

Parameters:
- WARN_LEVEL, 4: a battery whose charge is strictly below this value raises its warning (range 1..15).
- TH_REGULAR, 8: minimum combined charge for regular (range 1..30).
- TH_ACEPTABLE, 16: minimum combined charge for aceptable (must be > TH_REGULAR).
- TH_OPTIMO, 24: minimum combined charge for optimo (must be > TH_ACEPTABLE, ≤ 30).
- STABLE_CYCLES, 2: number of consecutive samples with the same candidate class needed to commit it (range 1..15).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- carga_bateria1  input  4  charge of battery 1, unsigned 0..15.
- carga_bateria2  input  4  charge of battery 2, unsigned 0..15.
- advertencia_bateria_1  output  1  battery 1 low-charge warning, registered.
- advertencia_bateria_2  output  1  battery 2 low-charge warning, registered.
- optimo  output  1  combined charge class optimo, registered.
- aceptable  output  1  combined charge class aceptable, registered.
- regular  output  1  combined charge class regular, registered.
- critico  output  1  combined charge class critico, registered.

Behaviour:
- Reset (asynchronous, takes effect immediately, held while rst=1):
  - advertencia_bateria_1 = 1, advertencia_bateria_2 = 1.
  - critico = 1; optimo, aceptable and regular = 0.
  - Internal pending class = critico; stability counter = 0.
- Warnings:
  - At each rising edge, advertencia_bateria_N <= (carga_bateriaN < WARN_LEVEL).
  - Latency is exactly 1 cycle. There is no filtering and no hysteresis.
- Combined charge: sum = carga_bateria1 + carga_bateria2, computed at 5 bits (0..30) with no overflow.
- Candidate class, computed combinationally from sum:
  - sum ≥ TH_OPTIMO → optimo.
  - TH_ACEPTABLE ≤ sum < TH_OPTIMO → aceptable.
  - TH_REGULAR ≤ sum < TH_ACEPTABLE → regular.
  - sum < TH_REGULAR → critico.
- Stability filter, evaluated at each rising edge:
  - If candidate ≠ pending: pending <= candidate and counter <= 1.
  - Otherwise counter increments, saturating at STABLE_CYCLES.
  - The committed class takes the pending value at the edge where the count of consecutive samples equal to pending (including the current one) reaches STABLE_CYCLES.
  - With STABLE_CYCLES = 1, the class follows the candidate with 1-cycle latency.
  - With the default of 2, an input held constant from before edge k commits at edge k+1.
- Glitches shorter than STABLE_CYCLES samples never change the class outputs. The previously committed class is held.
- The class outputs are always exactly one-hot, including during and immediately after reset. There are no unregistered output paths.
- Boundary mapping with default parameters:
  - sum 7 → critico; sum 8 → regular.
  - sum 15 → regular; sum 16 → aceptable.
  - sum 23 → aceptable; sum 24 → optimo.
- Warning boundaries with default parameters: charge 3 → warning = 1; charge 4 → warning = 0.
- Reset asserted mid-filter discards the pending class and counter. After reset release, a class other than critico needs a full STABLE_CYCLES of stable samples to commit.
- The two warnings are independent of each other and of the class filter.

Test Plan:
- Reset with inputs (15,15) → warnings 1,1 and critico = 1 until release. After release, warnings go 0,0 at the first edge and optimo = 1 at the second edge.
- Sequence (0,0), (8,0), (8,8), (15,0), (15,15), (5,6), each held 10 cycles → class critico, regular, aceptable, regular, optimo, regular. Warnings (1,1), (0,1), (0,0), (0,1), (0,0), (0,0).
- Boundaries with one input sweeping and the other input 0:
  - sum 7 → critico; sum 8 → regular.
  - (15,1) → sum 16 → aceptable.
  - (15,8) → sum 23 → aceptable; (15,9) → sum 24 → optimo.
  - Charge 3 vs 4 → warning 1 vs 0.
- Glitch test: steady (15,15) committed optimo, then (0,0) for exactly 1 cycle, then back to (15,15) → optimo never drops; the warnings pulse to 1,1 for 1 cycle.
- Latency test: step from (0,0) to (8,8) at edge k → warnings fall at edge k and aceptable asserts at edge k+1.
- Asynchronous reset pulse between edges while optimo is committed → critico = 1 and warnings = 1,1 immediately, with no clock edge needed.
